// File: rtl/packet_types.sv
// Shared flit and FSM types for the VC-aware CPU-to-NoC flitizer.
// Head flit fields are laid out in NODE_ID_W-wide slots from the LSB.
package packet_types;

    typedef enum logic [1:0] {
        FT_BODY     = 2'b00,
        FT_HEAD     = 2'b01,
        FT_TAIL     = 2'b10,
        FT_HEADTAIL = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_BODY
    } flitizer_state_t;

    localparam int HEAD_DST_FIELD = 0;
    localparam int HEAD_SRC_FIELD = 1;
    localparam int HEAD_LEN_FIELD = 2;

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for one router input buffer (one virtual channel).
// A return at full credit with no send holds the count and flags overflow.
module noc_credit_counter #(
    parameter int BUF_DEPTH = 4,
    localparam int CW = $clog2(BUF_DEPTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic overflow
);

    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d  = count_q;
        overflow = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (count_q == FULL) overflow = 1'b1;
                else count_d = count_q + 1'b1;
            end
            2'b01: begin
                if (count_q != '0) count_d = count_q - 1'b1;
            end
            default: ;
        endcase
    end

    assign nonzero = (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= FULL;
        else count_q <= count_d;
    end

endmodule

// File: rtl/cpu_to_noc_flitizer_vc.sv
// Turns one CPU packet request into head/body/tail flits on a credited VC.
// Optional CPU_TO_NOC_FLITIZER_PARITY_EN adds a registered even-parity bit.
module cpu_to_noc_flitizer_vc
    import packet_types::*;
#(
    parameter int FLIT_DATA_W = 32,
    parameter int MAX_BODY    = 4,
    parameter int NUM_VC      = 2,
    parameter int NODE_ID_W   = 8,
    parameter int SRC_ID      = 0,
    parameter int BUF_DEPTH   = 4,
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int LEN_W = $clog2(MAX_BODY + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cpu_valid,
    output logic                          cpu_ready,
    input  logic [NODE_ID_W-1:0]          cpu_dst_id,
    input  logic [VC_W-1:0]               cpu_vc,
    input  logic [LEN_W-1:0]              cpu_len,
    input  logic [MAX_BODY*FLIT_DATA_W-1:0] cpu_payload,
    output logic                          noc_flit_valid,
    input  logic                          noc_flit_ready,
    output logic [1:0]                    noc_flit_type,
    output logic [VC_W-1:0]               noc_flit_vc,
    output logic [FLIT_DATA_W-1:0]        noc_flit_data,
`ifdef CPU_TO_NOC_FLITIZER_PARITY_EN
    output logic                          noc_flit_parity,
`endif
    input  logic [NUM_VC-1:0]             noc_credit_ret,
    output logic                          credit_err,
    output logic                          busy
);

    localparam int IDX_W = (MAX_BODY > 1) ? $clog2(MAX_BODY) : 1;

    flitizer_state_t state_q, state_d;
    flit_type_t      type_q, type_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [VC_W-1:0]        vc_q, vc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [FLIT_DATA_W-1:0] data_q, data_d;
    logic [FLIT_DATA_W-1:0] payload_q [MAX_BODY];
    logic [FLIT_DATA_W-1:0] payload_d [MAX_BODY];
    logic                   err_q, err_d;
`ifdef CPU_TO_NOC_FLITIZER_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    logic [NUM_VC-1:0]      credit_nz;
    logic [NUM_VC-1:0]      credit_ovf;
    logic [NUM_VC-1:0]      credit_dec;
    logic                   fire;
    logic [LEN_W-1:0]       len_in;
    logic [VC_W-1:0]        vc_in;
    logic [FLIT_DATA_W-1:0] head_data;

    // Credits only rise while waiting, so valid never drops before handshake
    assign noc_flit_valid = (state_q != S_IDLE) && credit_nz[vc_q];
    assign fire           = noc_flit_valid && noc_flit_ready;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign credit_dec[v] = fire && (32'(vc_q) == v);
        noc_credit_counter #(
            .BUF_DEPTH(BUF_DEPTH)
        ) u_credit (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (noc_credit_ret[v]),
            .dec     (credit_dec[v]),
            .nonzero (credit_nz[v]),
            .overflow(credit_ovf[v])
        );
    end

    always_comb begin
        len_in = (32'(cpu_len) > MAX_BODY) ? LEN_W'(MAX_BODY) : cpu_len;
        vc_in  = VC_W'(32'(cpu_vc) % NUM_VC);
        head_data = '0;
        head_data[HEAD_DST_FIELD*NODE_ID_W +: NODE_ID_W] = cpu_dst_id;
        head_data[HEAD_SRC_FIELD*NODE_ID_W +: NODE_ID_W] = NODE_ID_W'(SRC_ID);
        head_data[HEAD_LEN_FIELD*NODE_ID_W +: LEN_W]     = len_in;
    end

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        len_d     = len_q;
        vc_d      = vc_q;
        idx_d     = idx_q;
        data_d    = data_q;
        payload_d = payload_q;
        err_d     = err_q | (|credit_ovf);
        case (state_q)
            S_IDLE: begin
                if (cpu_valid) begin
                    len_d  = len_in;
                    vc_d   = vc_in;
                    data_d = head_data;
                    type_d = (len_in == '0) ? FT_HEADTAIL : FT_HEAD;
                    for (int i = 0; i < MAX_BODY; i++)
                        payload_d[i] = cpu_payload[i*FLIT_DATA_W +: FLIT_DATA_W];
                    state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                if (fire) begin
                    if (len_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_BODY;
                        idx_d   = '0;
                        data_d  = payload_q[0];
                        type_d  = (32'(len_q) == 1) ? FT_TAIL : FT_BODY;
                    end
                end
            end
            S_BODY: begin
                if (fire) begin
                    if (32'(idx_q) + 1 == 32'(len_q)) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        data_d = payload_q[idx_q + 1'b1];
                        type_d = (32'(idx_q) + 2 == 32'(len_q)) ? FT_TAIL : FT_BODY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef CPU_TO_NOC_FLITIZER_PARITY_EN
        parity_d = ^{type_d, vc_d, data_d};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            type_q  <= FT_BODY;
            len_q   <= '0;
            vc_q    <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < MAX_BODY; i++) payload_q[i] <= '0;
`ifdef CPU_TO_NOC_FLITIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            len_q     <= len_d;
            vc_q      <= vc_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            err_q     <= err_d;
            payload_q <= payload_d;
`ifdef CPU_TO_NOC_FLITIZER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign cpu_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign noc_flit_type = type_q;
    assign noc_flit_vc   = vc_q;
    assign noc_flit_data = data_q;
    assign credit_err    = err_q;
`ifdef CPU_TO_NOC_FLITIZER_PARITY_EN
    assign noc_flit_parity = parity_q;
`endif

endmodule

// File: doc/cpu_to_noc_flitizer_vc.md
Name: cpu_to_noc_flitizer_vc

Overview:
Converts one CPU-side packet request into a stream of NoC flits: a head flit, then 0..MAX_BODY body flits, with the last one marked tail.
Generalises the single-channel flitizer to parametrised flit width, body depth and virtual-channel count.
Adds per-VC credit-based flow control toward the router input buffers.
Sits between the CPU bus bridge and the local router injection port.

Parameters:
FLIT_DATA_W, 32, data bits per flit
MAX_BODY, 4, maximum body flits per packet (>=1)
NUM_VC, 2, virtual channels (>=1)
NODE_ID_W, 8, node id width
SRC_ID, 0, this node's id, inserted in head flits
BUF_DEPTH, 4, router input buffer depth per VC = initial credits

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_valid  in  1  packet request valid
cpu_ready  out  1  packet request accepted when valid&ready
cpu_dst_id  in  NODE_ID_W  destination node
cpu_vc  in  $clog2(NUM_VC) (min 1)  target VC
cpu_len  in  $clog2(MAX_BODY+1)  body flit count
cpu_payload  in  MAX_BODY*FLIT_DATA_W  body words, word 0 in LSBs
noc_flit_valid  out  1  flit valid
noc_flit_ready  in  1  router accepts flit
noc_flit_type  out  2  HEAD=01, BODY=00, TAIL=10, HEADTAIL=11
noc_flit_vc  out  $clog2(NUM_VC) (min 1)  flit VC
noc_flit_data  out  FLIT_DATA_W  flit data
noc_credit_ret  in  NUM_VC  one-cycle credit return pulse per VC
credit_err  out  1  sticky credit-overflow flag
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; cpu_ready=1; noc_flit_valid=0.
  - type/vc/data=0; credit_err=0; busy=0; every credit counter=BUF_DEPTH.
- FSM states: IDLE, HEAD, BODY.
  - IDLE: cpu_ready=1. On cpu_valid, latch dst, vc, len and payload; go to HEAD next cycle. cpu_ready=0 in every other state (single-packet buffer).
  - HEAD: noc_flit_valid = (credit[vc] != 0).
    - Head data: bits [NODE_ID_W-1:0]=dst, [2*NODE_ID_W-1:NODE_ID_W]=SRC_ID, next field=len; upper bits 0.
    - Type is HEADTAIL when len==0, else HEAD.
    - On handshake: go to IDLE if len==0, else go to BODY with idx=0.
  - BODY: noc_flit_valid = (credit[vc] != 0); data = payload word idx.
    - Type is TAIL when idx==len-1, else BODY.
    - On handshake: idx++. After the tail flit, go to IDLE.
- Latency: request accepted at cycle N -> head valid at N+1 if credit is available. Throughput is 1 flit/cycle, no bubbles inside a packet. One idle cycle between packets (IDLE re-accept).
- Valid stability: credits only rise while waiting, so once noc_flit_valid=1 it holds with stable type/vc/data until the handshake.
- Credits: width $clog2(BUF_DEPTH+1).
  - Decrement on a flit handshake on that VC.
  - Increment on noc_credit_ret[v].
  - Simultaneous send and return on the same VC: count unchanged.
  - Return while already at BUF_DEPTH with no send: count holds, credit_err set sticky (cleared only by reset).
- cpu_len > MAX_BODY: clamped to MAX_BODY at latch.
- cpu_vc >= NUM_VC: wraps modulo NUM_VC at latch.
- Reset mid-packet: immediate abort to the reset state. The remaining flits are never sent, and credits restore to BUF_DEPTH.

Optional Feature:
CPU_TO_NOC_FLITIZER_PARITY_EN.
- Defined: adds output port noc_flit_parity (1 bit) = even parity (XOR-reduce) over {type, vc, data}. It is registered together with the flit fields and is 0 at reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package packet_types: flit_type_t enum (HEAD, BODY, TAIL, HEADTAIL), head-flit field offset constants, and the flitizer_state_t enum.
- Natural sub-module: noc_credit_counter (one per VC via generate). It has inc/dec inputs, a nonzero output and an overflow output.

Test Plan:
1. Reset, then request dst=5, vc=0, len=0, noc_flit_ready=1 -> one HEADTAIL flit at N+1 with data[7:0]=5, data[15:8]=SRC_ID, len field=0; busy returns to 0 next cycle.
2. len=3, payload words A0,A1,A2 -> HEAD, BODY A0, BODY A1, TAIL A2 on 4 consecutive cycles; credit[0] goes 4 -> 0.
3. noc_flit_ready held 0 for 3 cycles during BODY -> valid, type and data held stable; resumes correctly when ready returns to 1.
4. Credits exhausted on vc=1 (4 flits, no return) -> valid=0. Pulse noc_credit_ret[1] -> valid=1 the next cycle. Simultaneous send+return keeps the count constant.
5. Extra noc_credit_ret[0] pulse at full credit -> credit_err=1 and stays set; cleared only by rst_n.
6. Assert rst_n=0 mid-packet (after the head flit) -> outputs go to reset values immediately; the next packet starts with a clean head flit and full credits. With PARITY_EN, check parity on every flit.
